// File: rtl/cmp_minmax_sched_pkg.sv
// Shared types and constants for the min/max burst scheduler and its comparator.
package cmp_minmax_sched_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_MAX_LEN = 16;

    localparam logic [1:0] CMP_GT = 2'b10;
    localparam logic [1:0] CMP_LT = 2'b01;
    localparam logic [1:0] CMP_EQ = 2'b00;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT    = 3'd1,
        CMP_MAX = 3'd2,
        CMP_MIN = 3'd3,
        DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/cmp_minmax_sched_mag_cmp.sv
// Combinational unsigned magnitude comparator producing a 2-bit relation code.
module mag_cmp
    import cmp_minmax_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [1:0]       code
);

    // Relation of a to b.
    always_comb begin
        code = CMP_EQ;
        if (a > b) begin
            code = CMP_GT;
        end else if (b > a) begin
            code = CMP_LT;
        end else begin
            code = CMP_EQ;
        end
    end

endmodule

// File: rtl/cmp_minmax_sched.sv
// Burst min/max finder that time-shares one comparator: each sample after the
// first is checked against the running max, then against the running min.
module cmp_minmax_sched
    import cmp_minmax_sched_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int IDXW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [IDXW:0]    len,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] min_val,
    output logic [IDXW-1:0]  max_idx,
    output logic [IDXW-1:0]  min_idx
);

    localparam logic [IDXW:0] MAX_LEN_W = (IDXW+1)'(MAX_LEN);
    localparam logic [IDXW:0] ONE_W     = (IDXW+1)'(1);

    state_t            state_r, state_next;
    logic [IDXW:0]     len_r, count_r;
    logic [WIDTH-1:0]  hold_val_r, max_val_r, min_val_r;
    logic [IDXW-1:0]   hold_idx_r, max_idx_r, min_idx_r;
    logic              in_ready_r, busy_r, done_r, err_r;
    logic              accept_s, start_ok_s, start_bad_s;
    logic [WIDTH-1:0]  cmp_a_s, cmp_b_s;
    logic [1:0]        cmp_code_s;

    mag_cmp #(.WIDTH(WIDTH)) u_cmp (
        .a    (cmp_a_s),
        .b    (cmp_b_s),
        .code (cmp_code_s)
    );

    // Operand steering: CMP_MIN asks "is min above the sample", otherwise "is the sample above max".
    always_comb begin
        cmp_a_s = hold_val_r;
        cmp_b_s = max_val_r;
        if (state_r == CMP_MIN) begin
            cmp_a_s = min_val_r;
            cmp_b_s = hold_val_r;
        end else begin
            cmp_a_s = hold_val_r;
            cmp_b_s = max_val_r;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        state_next  = state_r;
        accept_s    = 1'b0;
        start_ok_s  = 1'b0;
        start_bad_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if ((len == '0) || (len > MAX_LEN_W)) begin
                        start_bad_s = 1'b1;
                    end else begin
                        start_ok_s = 1'b1;
                        state_next = WAIT;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            WAIT: begin
                if (in_valid && in_ready_r) begin
                    accept_s = 1'b1;
                    if (count_r == '0) begin
                        state_next = (len_r == ONE_W) ? DONE : WAIT;
                    end else begin
                        state_next = CMP_MAX;
                    end
                end else begin
                    state_next = WAIT;
                end
            end
            CMP_MAX: state_next = CMP_MIN;
            CMP_MIN: begin
                if (count_r == len_r) begin
                    state_next = DONE;
                end else begin
                    state_next = WAIT;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // Datapath and registered status outputs; status flags follow the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_r      <= '0;
            count_r    <= '0;
            hold_val_r <= '0;
            hold_idx_r <= '0;
            max_val_r  <= '0;
            min_val_r  <= '0;
            max_idx_r  <= '0;
            min_idx_r  <= '0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            in_ready_r <= (state_next == WAIT);
            busy_r     <= (state_next != IDLE);
            done_r     <= (state_next == DONE);
            err_r      <= start_bad_s;
            if (start_ok_s) begin
                len_r     <= len;
                count_r   <= '0;
                max_val_r <= '0;
                min_val_r <= '0;
                max_idx_r <= '0;
                min_idx_r <= '0;
            end else if (accept_s) begin
                if (count_r == '0) begin
                    max_val_r <= in_data;
                    min_val_r <= in_data;
                    max_idx_r <= '0;
                    min_idx_r <= '0;
                    count_r   <= ONE_W;
                end else begin
                    hold_val_r <= in_data;
                    hold_idx_r <= count_r[IDXW-1:0];
                    count_r    <= count_r + ONE_W;
                end
            end else if ((state_r == CMP_MAX) && (cmp_code_s == CMP_GT)) begin
                max_val_r <= hold_val_r;
                max_idx_r <= hold_idx_r;
            end else if ((state_r == CMP_MIN) && (cmp_code_s == CMP_GT)) begin
                min_val_r <= hold_val_r;
                min_idx_r <= hold_idx_r;
            end else begin
                count_r <= count_r;
            end
        end
    end

    assign in_ready = in_ready_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign err      = err_r;
    assign max_val  = max_val_r;
    assign min_val  = min_val_r;
    assign max_idx  = max_idx_r;
    assign min_idx  = min_idx_r;

endmodule

// File: tb/tb_cmp_minmax_sched.sv
// Self-checking bench for cmp_minmax_sched: directed and random bursts against a reference model.
module tb_cmp_minmax_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [4:0] len = 5'd0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_ready, busy, done, err;
    logic [7:0] max_val, min_val;
    logic [3:0] max_idx, min_idx;

    int n_assert = 0;
    int n_fail   = 0;
    logic [7:0] samp [16];

    cmp_minmax_sched #(.WIDTH(8), .MAX_LEN(16), .IDXW(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .busy(busy), .done(done), .err(err),
        .max_val(max_val), .min_val(min_val), .max_idx(max_idx), .min_idx(min_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd0);
        check({tag, ".busy"},     32'(busy),     32'd0);
        check({tag, ".done"},     32'(done),     32'd0);
        check({tag, ".err"},      32'(err),      32'd0);
        check({tag, ".max_val"},  32'(max_val),  32'd0);
        check({tag, ".min_val"},  32'(min_val),  32'd0);
        check({tag, ".max_idx"},  32'(max_idx),  32'd0);
        check({tag, ".min_idx"},  32'(min_idx),  32'd0);
    endtask

    // Runs one burst of samp[0..n-1]; called right after a negedge.
    task automatic run_burst(input string tag, input int n, input bit toggle, input bit chk_lat);
        int cyc, idx, first, done_cyc, done_cnt, cooldown, viol;
        int exp_max, exp_min, exp_max_i, exp_min_i;
        exp_max = samp[0]; exp_min = samp[0]; exp_max_i = 0; exp_min_i = 0;
        for (int i = 1; i < n; i++) begin
            if (samp[i] > exp_max) begin exp_max = samp[i]; exp_max_i = i; end
            if (samp[i] < exp_min) begin exp_min = samp[i]; exp_min_i = i; end
        end
        start = 1'b1; len = 5'(n);
        @(negedge clk);
        start = 1'b0;
        check({tag, ".busy_after_start"}, 32'(busy), 32'd1);
        cyc = 0; idx = 0; first = -1; done_cyc = -1; done_cnt = 0; cooldown = 0; viol = 0;
        while (cyc < 300) begin
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (in_ready && (cooldown > 0 || done)) viol++;
            if (cooldown > 0) cooldown--;
            in_valid = (idx < n) && (!toggle || (cyc % 2 == 0));
            in_data  = (idx < n) ? samp[idx] : 8'd0;
            if (in_valid && in_ready) begin
                if (idx == 0) first = cyc; else cooldown = 2;
                idx++;
            end
            if (done_cnt > 0 && cyc >= done_cyc + 2) break;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check({tag, ".samples_taken"}, 32'(idx), 32'(n));
        check({tag, ".done_pulses"}, 32'(done_cnt), 32'd1);
        check({tag, ".ready_outside_wait"}, 32'(viol), 32'd0);
        if (chk_lat) check({tag, ".latency"}, 32'(done_cyc - first), 32'(3 * n - 2));
        check({tag, ".max_val"}, 32'(max_val), 32'(exp_max));
        check({tag, ".max_idx"}, 32'(max_idx), 32'(exp_max_i));
        check({tag, ".min_val"}, 32'(min_val), 32'(exp_min));
        check({tag, ".min_idx"}, 32'(min_idx), 32'(exp_min_i));
        check({tag, ".busy_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int cnt, err_seen, rn;
        #3;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        samp[0] = 8'd7; samp[1] = 8'd200; samp[2] = 8'd3; samp[3] = 8'd200; samp[4] = 8'd3;
        run_burst("len5", 5, 1'b0, 1'b1);

        samp[0] = 8'h55;
        run_burst("len1", 1, 1'b0, 1'b1);

        // Rejected starts: err pulses, no busy, results kept.
        start = 1'b1; len = 5'd0;
        @(negedge clk);
        start = 1'b0;
        check("len0.err", 32'(err), 32'd1);
        check("len0.busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("len0.err_pulse", 32'(err), 32'd0);
        start = 1'b1; len = 5'd17;
        @(negedge clk);
        start = 1'b0;
        check("len17.err", 32'(err), 32'd1);
        check("len17.busy", 32'(busy), 32'd0);
        check("len17.max_kept", 32'(max_val), 32'h55);
        check("len17.min_kept", 32'(min_val), 32'h55);
        @(negedge clk);

        for (int i = 0; i < 16; i++) samp[i] = 8'(255 - 17 * i);
        samp[15] = 8'd0;
        run_burst("ramp16", 16, 1'b1, 1'b0);

        for (int i = 0; i < 4; i++) samp[i] = 8'h80;
        run_burst("equal4", 4, 1'b0, 1'b1);

        // Mid-burst restart attempt, then asynchronous reset.
        start = 1'b1; len = 5'd4;
        @(negedge clk);
        start = 1'b0; cnt = 0; err_seen = 0;
        for (int k = 0; k < 20 && cnt < 2; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(40 + k);
            if (in_ready) cnt++;
            start = (k == 1);
            len   = 5'd2;
            @(negedge clk);
            if (err) err_seen++;
        end
        in_valid = 1'b0; start = 1'b0;
        check("mid.accepted", 32'(cnt), 32'd2);
        check("mid.no_err", 32'(err_seen), 32'd0);
        check("mid.busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        samp[0] = 8'd9; samp[1] = 8'd1;
        run_burst("after_reset", 2, 1'b0, 1'b1);

        // Random bursts, some with narrow data to force ties.
        for (int r = 0; r < 6; r++) begin
            rn = $urandom_range(1, 16);
            for (int i = 0; i < rn; i++)
                samp[i] = (r % 2 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(10, 13));
            run_burst($sformatf("rand%0d", r), rn, 1'(r % 3 == 2), 1'(r % 3 != 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cmp_minmax_sched.md
Name: cmp_minmax_sched

Overview:
- Scheduler that streams a burst of 1..MAX_LEN unsigned samples through one shared magnitude comparator. Reports the maximum and minimum values and the index of each.
- The single comparator is time-shared: each sample is compared first against the running max, then against the running min.
- Sits between a sample source (valid/ready) and a host that issues start and consumes done.

Parameters:
- WIDTH, 8, sample width in bits
- MAX_LEN, 16, maximum samples per burst
- IDXW, 4, index width; must equal clog2(MAX_LEN)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin burst; sampled only in IDLE
- len  in  IDXW+1  burst length; latched on accepted start
- in_valid  in  1  sample valid
- in_data  in  WIDTH  sample value, unsigned
- in_ready  out  1  block accepts a sample this cycle
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when results are valid
- err  out  1  one-cycle pulse on a rejected start
- max_val  out  WIDTH  largest sample in burst
- min_val  out  WIDTH  smallest sample in burst
- max_idx  out  IDXW  index of first occurrence of max
- min_idx  out  IDXW  index of first occurrence of min

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; all outputs 0, including in_ready, busy, done, err, max/min values and indices. Internal count and latched len are also 0.
- Comparator code (sub-module, combinational): 2'b10 when a>b, 2'b01 when b>a, 2'b00 when equal.
- States: IDLE, WAIT, CMP_MAX, CMP_MIN, DONE. busy = (state != IDLE).
- IDLE, start=1:
  - If len==0 or len>MAX_LEN: err=1 next cycle and stay IDLE; result outputs unchanged.
  - Otherwise: latch len, clear count, clear max/min values and indices, go to WAIT.
- WAIT: in_ready=1. A sample is accepted on in_valid && in_ready.
  - Accepted with count==0: max_val=min_val=in_data, both indices=0, count=1. Go to DONE if len==1, else stay in WAIT.
  - Accepted with count>0: capture sample and index=count into holding registers, count+=1, go to CMP_MAX.
- CMP_MAX: in_ready=0. Comparator a=held sample, b=max_val. On code 2'b10, max_val and max_idx take the held sample and its index. Go to CMP_MIN.
- CMP_MIN: in_ready=0. Comparator a=min_val, b=held sample. On code 2'b10, min_val and min_idx take the held sample and its index. Go to DONE if count==len, else WAIT.
- Ties: a strict comparison only updates; on equal values the earlier index is kept.
- DONE: done=1 for exactly this cycle; in_ready=0. Next state is IDLE.
- Result outputs hold after DONE until the next accepted start clears them.
- Throughput: first sample 1 cycle, each later sample 3 cycles.
- Latency: last sample accepted at cycle t -> done at t+3. For len==1, sample accepted at t -> done at t+1.
- start while busy is ignored, with no err. in_valid outside WAIT is ignored and no data is consumed.
- in_data is treated as unsigned; no arithmetic wrap occurs. count is IDXW+1 bits so that count==MAX_LEN is representable.
- Reset mid-burst: immediately IDLE with all outputs 0. The partial burst is discarded; the source must re-issue it after a new start.

Decomposition:
- Shared package holds:
  - state enum: IDLE, WAIT, CMP_MAX, CMP_MIN, DONE
  - comparator code constants: CMP_GT=2'b10, CMP_LT=2'b01, CMP_EQ=2'b00
  - defaults for WIDTH and MAX_LEN
- One sub-module, mag_cmp: parameterized WIDTH, combinational, ports a, b, code[1:0]. It is instantiated once; the scheduler muxes its operands by state.

Test Plan:
- Reset release, then start with len=5 and samples 7,200,3,200,3 -> done 13 cycles after the first accept; max_val=200, max_idx=1, min_val=3, min_idx=2 (ties keep earliest).
- len=1, sample 0x55 -> done 1 cycle after accept; max=min=0x55, both indices 0.
- start with len=0, then with len=17 -> err pulse each time; busy stays 0; prior results unchanged.
- len=16, ramp 255 down to 0 with in_valid toggling every other cycle -> in_ready only in WAIT; max=255 idx 0; min=0 idx 15; exactly one done pulse.
- Reassert start mid-burst, then drop rst_n after 2 of 4 samples -> start ignored with no err; all outputs 0 immediately; a new burst 9,1 runs correctly to max=9 idx 0, min=1 idx 1.
- All-equal burst, len=4, value 0x80 -> max_idx=min_idx=0; done 10 cycles after the first accept.
